multi_alarm_ctrl: RTL and testbench

Keypad/button control FSM for the alarm clock, generalised to NUM_ALARMS independently loadable alarm registers, a parametrised key-entry timeout and digit count, and partial-entry rejection. It sits between the debounced keypad/buttons and the time/alarm datapath (digit shift register, current-time counter, alarm registers, display mux). It only issues control strobes and selects; it holds no time data.

---
 rtl/multi_alarm_ctrl.sv | 130 +++++++++++++
 tb/tb_multi_alarm_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/multi_alarm_ctrl.sv
// Keypad/button control FSM for a multi-alarm clock: sequences digit entry and
// issues shift/load/select strobes to the time and alarm datapath.
module multi_alarm_ctrl #(
  parameter int         NUM_ALARMS  = 4,
  parameter int         DIGITS      = 4,
  parameter int         KEY_TIMEOUT = 10,
  parameter logic [3:0] NO_KEY      = 4'd10,
  parameter int         SEL_W       = $clog2(NUM_ALARMS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  one_second,
  input  logic                  time_button,
  input  logic                  alarm_button,
  input  logic [SEL_W-1:0]      alarm_sel,
  input  logic [3:0]            key,
  output logic                  shift,
  output logic                  show_new_time,
  output logic                  show_a,
  output logic [SEL_W-1:0]      alarm_idx,
  output logic [NUM_ALARMS-1:0] load_new_a,
  output logic                  load_new_c,
  output logic                  reset_count,
  output logic                  entry_err,
  output logic [3:0]            digit_count
);

  localparam int TW = $clog2(KEY_TIMEOUT + 1);

  typedef enum logic [2:0] {
    SHOW_TIME, KEY_STORED, KEY_WAITED, KEY_ENTRY,
    SHOW_ALARM, SET_ALARM_TIME, SET_CUR_TIME, ENTRY_ERR
  } state_t;

  state_t           state, state_nxt;
  logic [3:0]       dc_nxt;
  logic [SEL_W-1:0] idx_nxt;
  logic [TW-1:0]    tcnt, tcnt_nxt;
  logic             need_release, need_release_nxt;
  logic             key_valid, timed_out, full, in_entry;

  assign key_valid = (key != NO_KEY) && (key <= 4'd9);
  assign timed_out = (tcnt == TW'(KEY_TIMEOUT));
  assign full      = (digit_count == 4'(DIGITS));
  assign in_entry  = (state == KEY_WAITED) || (state == KEY_ENTRY);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= SHOW_TIME;
      digit_count  <= '0;
      alarm_idx    <= '0;
      tcnt         <= '0;
      need_release <= 1'b0;
    end else begin
      state        <= state_nxt;
      digit_count  <= dc_nxt;
      alarm_idx    <= idx_nxt;
      tcnt         <= tcnt_nxt;
      need_release <= need_release_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    dc_nxt    = digit_count;
    idx_nxt   = alarm_idx;
    case (state)
      SHOW_TIME: begin
        if (alarm_button) begin
          state_nxt = SHOW_ALARM;
          idx_nxt   = alarm_sel;
        end else if (key_valid && !need_release) begin
          state_nxt = KEY_STORED;
          dc_nxt    = 4'd1;
        end
      end
      KEY_STORED: state_nxt = KEY_WAITED;
      KEY_WAITED: begin
        if (timed_out)       state_nxt = SHOW_TIME;
        else if (!key_valid) state_nxt = KEY_ENTRY;
      end
      KEY_ENTRY: begin
        // Commit buttons outrank timeout; alarm outranks time.
        if (alarm_button) begin
          if (full) begin
            state_nxt = SET_ALARM_TIME;
            idx_nxt   = alarm_sel;
          end else begin
            state_nxt = ENTRY_ERR;
          end
        end else if (time_button) begin
          state_nxt = full ? SET_CUR_TIME : ENTRY_ERR;
        end else if (timed_out) begin
          state_nxt = SHOW_TIME;
        end else if (key_valid && !full) begin
          state_nxt = KEY_STORED;
          dc_nxt    = digit_count + 4'd1;
        end
      end
      SHOW_ALARM: if (!alarm_button) state_nxt = SHOW_TIME;
      default:    state_nxt = SHOW_TIME;
    endcase
    if (state_nxt == SHOW_TIME) dc_nxt = '0;
  end

  always_comb begin
    tcnt_nxt = '0;
    if (in_entry) tcnt_nxt = (one_second && !timed_out) ? tcnt + TW'(1) : tcnt;
  end

  // A key still held when entry times out must be released before it counts again.
  always_comb begin
    need_release_nxt = need_release;
    if (!key_valid)
      need_release_nxt = 1'b0;
    else if (in_entry && timed_out && state_nxt == SHOW_TIME)
      need_release_nxt = 1'b1;
  end

  always_comb begin
    shift         = (state == KEY_STORED);
    show_new_time = (state == KEY_STORED) || in_entry;
    show_a        = (state == SHOW_ALARM);
    load_new_a    = (state == SET_ALARM_TIME) ? (NUM_ALARMS'(1) << alarm_idx) : '0;
    load_new_c    = (state == SET_CUR_TIME);
    reset_count   = (state == SET_CUR_TIME);
    entry_err     = (state == ENTRY_ERR);
  end

endmodule

// File: tb/tb_multi_alarm_ctrl.sv
// Bench for multi_alarm_ctrl: vector table plus hand sequences, checked through
// an expected-output queue filled as stimulus is driven.
module tb_multi_alarm_ctrl;

  localparam logic [3:0] NK = 4'd10;

  logic       clk = 1'b0;
  logic       reset, one_second, time_button, alarm_button;
  logic [1:0] alarm_sel;
  logic [3:0] key;
  logic       shift, show_new_time, show_a, load_new_c, reset_count, entry_err;
  logic [1:0] alarm_idx;
  logic [3:0] load_new_a, digit_count;

  multi_alarm_ctrl #(.NUM_ALARMS(4), .DIGITS(4), .KEY_TIMEOUT(10), .NO_KEY(4'd10)) dut (
    .clk(clk), .reset(reset), .one_second(one_second), .time_button(time_button),
    .alarm_button(alarm_button), .alarm_sel(alarm_sel), .key(key), .shift(shift),
    .show_new_time(show_new_time), .show_a(show_a), .alarm_idx(alarm_idx),
    .load_new_a(load_new_a), .load_new_c(load_new_c), .reset_count(reset_count),
    .entry_err(entry_err), .digit_count(digit_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       sh, snt, sa;
    logic [1:0] idx;
    logic [3:0] la;
    logic       lc, rc, err;
    logic [3:0] dc;
  } out_t;

  typedef struct {
    logic       os, tb, ab;
    logic [1:0] sel;
    logic [3:0] key;
    out_t       exp;
  } vec_t;

  out_t act;
  assign act = {shift, show_new_time, show_a, alarm_idx, load_new_a,
                load_new_c, reset_count, entry_err, digit_count};

  int   n_cmp = 0;
  int   n_bad = 0;
  out_t sb[$];
  vec_t tbl[$];

  function automatic out_t o(input logic sh, snt, sa, input logic [1:0] idx,
                             input logic [3:0] la, input logic lc, err,
                             input logic [3:0] dc);
    out_t r;
    r = '{sh: sh, snt: snt, sa: sa, idx: idx, la: la, lc: lc, rc: lc, err: err, dc: dc};
    return r;
  endfunction

  task automatic check(input string name);
    out_t e;
    e = sb.pop_front();
    n_cmp++;
    if (act !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, e);
    end
  endtask

  task automatic step(input string name, input logic os, tb, ab, input logic [1:0] sel,
                      input logic [3:0] k, input out_t e, input bit chk);
    one_second = os; time_button = tb; alarm_button = ab; alarm_sel = sel; key = k;
    if (chk) sb.push_back(e);
    @(posedge clk); #1;
    if (chk) check(name);
  endtask

  // One keypress in entry: held two cycles, then released.
  task automatic press(input string name, input logic [3:0] k, input logic [3:0] dc,
                       input logic sh, input logic [1:0] idx);
    step(name, 0, 0, 0, 0, k,  o(sh, 1, 0, idx, 0, 0, 0, dc), 1);
    step(name, 0, 0, 0, 0, k,  o(0,  1, 0, idx, 0, 0, 0, dc), 1);
    step(name, 0, 0, 0, 0, NK, o(0,  1, 0, idx, 0, 0, 0, dc), 1);
  endtask

  task automatic idle(input string name, input logic [1:0] idx);
    step(name, 0, 0, 0, 0, NK, o(0, 0, 0, idx, 0, 0, 0, 0), 1);
  endtask

  initial begin
    reset = 1'b1; one_second = 0; time_button = 0; alarm_button = 0;
    alarm_sel = 0; key = NK;
    repeat (2) @(posedge clk);
    #1;
    sb.push_back(o(0, 0, 0, 0, 0, 0, 0, 0));
    check("reset_state");
    reset = 1'b0;

    // Set current time 1,2,3,0, each key held three cycles.
    tbl.push_back('{0, 0, 0, 0, 4'd12, o(0, 0, 0, 0, 0, 0, 0, 0)});
    for (int d = 0; d < 4; d++) begin
      logic [3:0] kk;
      logic [3:0] dc;
      kk = (d == 3) ? 4'd0 : 4'(d + 1);
      dc = 4'(d + 1);
      tbl.push_back('{0, 0, 0, 0, kk, o(1, 1, 0, 0, 0, 0, 0, dc)});
      tbl.push_back('{0, 0, 0, 0, kk, o(0, 1, 0, 0, 0, 0, 0, dc)});
      tbl.push_back('{0, 0, 0, 0, kk, o(0, 1, 0, 0, 0, 0, 0, dc)});
      tbl.push_back('{0, 0, 0, 0, NK, o(0, 1, 0, 0, 0, 0, 0, dc)});
    end
    tbl.push_back('{0, 1, 0, 0, NK, o(0, 0, 0, 0, 0, 1, 0, 4)});
    tbl.push_back('{0, 0, 0, 0, NK, o(0, 0, 0, 0, 0, 0, 0, 0)});
    foreach (tbl[i])
      step($sformatf("set_time[%0d]", i), tbl[i].os, tbl[i].tb, tbl[i].ab,
           tbl[i].sel, tbl[i].key, tbl[i].exp, 1);

    // Alarm 2: four digits, fifth key ignored, commit.
    for (int d = 0; d < 4; d++) press("alarm_digit", 4'(d + 1), 4'(d + 1), 1, 0);
    press("fifth_key", 4'd9, 4, 0, 0);
    step("set_alarm2", 0, 0, 1, 2, NK, o(0, 0, 0, 2, 4'b0100, 0, 0, 4), 1);
    idle("after_alarm2", 2);

    // Partial entry rejected on alarm and on time commit.
    press("partial", 4'd7, 1, 1, 2);
    press("partial", 4'd5, 2, 1, 2);
    step("partial_alarm", 0, 0, 1, 1, NK, o(0, 0, 0, 2, 0, 0, 1, 2), 1);
    idle("after_partial", 2);
    press("partial_t", 4'd3, 1, 1, 2);
    step("partial_time", 0, 1, 0, 0, NK, o(0, 0, 0, 2, 0, 0, 1, 1), 1);
    idle("after_partial_t", 2);

    // Both buttons together: alarm wins.
    for (int d = 0; d < 4; d++) press("both_digit", 4'd8, 4'(d + 1), 1, 2);
    step("both_buttons", 0, 1, 1, 1, NK, o(0, 0, 0, 1, 4'b0010, 0, 0, 4), 1);
    idle("after_both", 1);

    // Timeout: nine ticks keep entry alive, a new key restarts the count.
    press("to_key", 4'd4, 1, 1, 1);
    for (int p = 0; p < 9; p++) begin
      step("to_nine", 1, 0, 0, 0, NK, o(0, 1, 0, 1, 0, 0, 0, 1), 1);
      step("to_nine", 0, 0, 0, 0, NK, o(0, 1, 0, 1, 0, 0, 0, 1), 1);
    end
    press("to_key2", 4'd8, 2, 1, 1);
    for (int p = 0; p < 9; p++) begin
      step("to_wait", 1, 0, 0, 0, NK, o(0, 1, 0, 1, 0, 0, 0, 2), 1);
      step("to_wait", 0, 0, 0, 0, NK, o(0, 1, 0, 1, 0, 0, 0, 2), 1);
    end
    step("to_tenth", 1, 0, 0, 0, NK, o(0, 0, 0, 0, 0, 0, 0, 0), 0);
    idle("timed_out", 1);

    // Key held through timeout must be released before it re-enters entry.
    step("held_press", 0, 0, 0, 0, 4'd6, o(1, 1, 0, 1, 0, 0, 0, 1), 1);
    step("held_wait", 0, 0, 0, 0, 4'd6, o(0, 1, 0, 1, 0, 0, 0, 1), 1);
    for (int p = 0; p < 9; p++) begin
      step("held_tick", 1, 0, 0, 0, 4'd6, o(0, 1, 0, 1, 0, 0, 0, 1), 1);
      step("held_tick", 0, 0, 0, 0, 4'd6, o(0, 1, 0, 1, 0, 0, 0, 1), 1);
    end
    step("held_tenth", 1, 0, 0, 0, 4'd6, o(0, 0, 0, 0, 0, 0, 0, 0), 0);
    step("held_timeout", 0, 0, 0, 0, 4'd6, o(0, 0, 0, 1, 0, 0, 0, 0), 1);
    step("held_no_reentry", 0, 0, 0, 0, 4'd6, o(0, 0, 0, 1, 0, 0, 0, 0), 1);
    idle("held_release", 1);
    press("repress", 4'd6, 1, 1, 1);

    // Reset mid-entry discards everything with no strobes.
    press("pre_reset", 4'd2, 2, 1, 1);
    reset = 1'b1;
    #1;
    sb.push_back(o(0, 0, 0, 0, 0, 0, 0, 0));
    check("reset_async");
    @(posedge clk); #1;
    sb.push_back(o(0, 0, 0, 0, 0, 0, 0, 0));
    check("reset_held");
    reset = 1'b0;
    idle("after_reset", 0);

    // Show alarm 3; index frozen while alarm_sel moves.
    for (int c = 0; c < 5; c++)
      step("show_alarm", 0, 0, 1, (c < 2) ? 2'd3 : 2'd0, NK, o(0, 0, 1, 3, 0, 0, 0, 0), 1);
    idle("show_release", 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
